// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for a 3x3 Sobel datapath: counts raster pixels, fires windows, thresholds results.
// Window and edge outputs are registered one cycle after their triggers; pixels are accepted only while streaming.
module sobel_frame_ctrl #(
    parameter int IMAGE_ROW_SIZE    = 8,
    parameter int IMAGE_COLUMN_SIZE = 8,
    parameter int THRESHOLD         = 100
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start_i,
    input  logic                                 pix_valid_i,
    output logic                                 pix_ready_o,
    output logic                                 lb_wr_en_o,
    output logic [$clog2(IMAGE_ROW_SIZE)-1:0]    lb_wr_row_o,
    output logic [$clog2(IMAGE_COLUMN_SIZE)-1:0] lb_wr_col_o,
    output logic                                 win_valid_o,
    output logic [$clog2(IMAGE_ROW_SIZE)-1:0]    win_row_o,
    output logic [$clog2(IMAGE_COLUMN_SIZE)-1:0] win_col_o,
    input  logic                                 mag_valid_i,
    input  logic [10:0]                          mag_i,
    output logic                                 edge_valid_o,
    output logic                                 edge_o,
    output logic                                 busy_o,
    output logic                                 done_o
);

    localparam int RW    = $clog2(IMAGE_ROW_SIZE);
    localparam int CW    = $clog2(IMAGE_COLUMN_SIZE);
    localparam int TOTAL = (IMAGE_ROW_SIZE - 2) * (IMAGE_COLUMN_SIZE - 2);
    localparam int NW    = $clog2(TOTAL + 1);

    localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_ROW_SIZE - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_COLUMN_SIZE - 1);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [NW-1:0] TOTAL_N  = NW'(TOTAL);
    localparam logic [10:0]   THR      = 11'(THRESHOLD);

    typedef enum logic [1:0] {IDLE, STREAM, WAIT_RES, DONE} state_t;

    state_t        state;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [NW-1:0] win_cnt;
    logic [NW-1:0] res_cnt;

    logic beat;
    logic final_beat;
    logic win_ok;
    logic res_ok;
    logic last_res;

    assign beat        = pix_valid_i & pix_ready_o;
    assign final_beat  = beat && (row == ROW_LAST) && (col == COL_LAST);
    assign win_ok      = beat && (row >= ROW_TWO) && (col >= COL_TWO) && (win_cnt != TOTAL_N);
    // Results outside an active frame, or beyond the frame's window count, are dropped.
    assign res_ok      = mag_valid_i && ((state == STREAM) || (state == WAIT_RES)) && (res_cnt != TOTAL_N);
    assign last_res    = res_ok && (res_cnt == TOTAL_N - NW'(1));

    assign lb_wr_en_o  = beat;
    assign lb_wr_row_o = row;
    assign lb_wr_col_o = col;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            row          <= '0;
            col          <= '0;
            win_cnt      <= '0;
            res_cnt      <= '0;
            pix_ready_o  <= 1'b0;
            win_valid_o  <= 1'b0;
            win_row_o    <= '0;
            win_col_o    <= '0;
            edge_valid_o <= 1'b0;
            edge_o       <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            win_valid_o  <= 1'b0;
            edge_valid_o <= 1'b0;
            done_o       <= 1'b0;

            if (win_ok) begin
                win_valid_o <= 1'b1;
                win_row_o   <= row - RW'(1);
                win_col_o   <= col - CW'(1);
                win_cnt     <= win_cnt + NW'(1);
            end

            if (res_ok) begin
                edge_valid_o <= 1'b1;
                edge_o       <= (mag_i > THR);
                res_cnt      <= res_cnt + NW'(1);
            end

            if (beat) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (start_i) begin
                        state       <= STREAM;
                        pix_ready_o <= 1'b1;
                        busy_o      <= 1'b1;
                        row         <= '0;
                        col         <= '0;
                        win_cnt     <= '0;
                        res_cnt     <= '0;
                    end
                end
                STREAM: begin
                    if (final_beat) begin
                        state       <= WAIT_RES;
                        pix_ready_o <= 1'b0;
                    end
                end
                WAIT_RES: begin
                    // res_cnt already includes any result taken on the final-beat cycle.
                    if ((res_cnt == TOTAL_N) || last_res) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    pix_ready_o <= 1'b0;
                    busy_o      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl: window sequencing, thresholding, completion and reset.
module tb_sobel_frame_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic        pix_valid_i;
    logic        pix_ready_o;
    logic        lb_wr_en_o;
    logic [2:0]  lb_wr_row_o;
    logic [2:0]  lb_wr_col_o;
    logic        win_valid_o;
    logic [2:0]  win_row_o;
    logic [2:0]  win_col_o;
    logic        mag_valid_i;
    logic [10:0] mag_i;
    logic        edge_valid_o;
    logic        edge_o;
    logic        busy_o;
    logic        done_o;

    sobel_frame_ctrl #(
        .IMAGE_ROW_SIZE(8),
        .IMAGE_COLUMN_SIZE(8),
        .THRESHOLD(100)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start_i(start_i),
        .pix_valid_i(pix_valid_i),
        .pix_ready_o(pix_ready_o),
        .lb_wr_en_o(lb_wr_en_o),
        .lb_wr_row_o(lb_wr_row_o),
        .lb_wr_col_o(lb_wr_col_o),
        .win_valid_o(win_valid_o),
        .win_row_o(win_row_o),
        .win_col_o(win_col_o),
        .mag_valid_i(mag_valid_i),
        .mag_i(mag_i),
        .edge_valid_o(edge_valid_o),
        .edge_o(edge_o),
        .busy_o(busy_o),
        .done_o(done_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [10:0] mag;
        logic        exp_edge;
    } vec_t;

    vec_t tbl [6];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raster model of the pixel stream plus window expectations, sampled on the falling edge.
    bit mon_en   = 1'b0;
    bit prev_int = 1'b0;
    int exp_r = 0, exp_c = 0, prev_r = 0, prev_c = 0;
    int win_seen = 0, first_r = -1, first_c = -1, last_r = -1, last_c = -1;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_int) begin
                chk("win_valid_o", win_valid_o, 1);
                chk("win_row_o", win_row_o, prev_r - 1);
                chk("win_col_o", win_col_o, prev_c - 1);
                if (win_seen == 0) begin
                    first_r = win_row_o;
                    first_c = win_col_o;
                end
                last_r = win_row_o;
                last_c = win_col_o;
                win_seen++;
            end else begin
                chk("win_valid_o_quiet", win_valid_o, 0);
            end
            prev_int = 1'b0;
            if (lb_wr_en_o) begin
                chk("lb_wr_row_o", lb_wr_row_o, exp_r);
                chk("lb_wr_col_o", lb_wr_col_o, exp_c);
                prev_int = (exp_r >= 2) && (exp_c >= 2);
                prev_r   = exp_r;
                prev_c   = exp_c;
                exp_c++;
                if (exp_c == 8) begin
                    exp_c = 0;
                    exp_r = (exp_r == 7) ? 0 : exp_r + 1;
                end
            end
        end
        if (done_o) done_cnt++;
        if (start_i && !busy_o && rst_n) begin
            exp_r    = 0;
            exp_c    = 0;
            win_seen = 0;
            prev_int = 1'b0;
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_pix_ready_o"}, pix_ready_o, 0);
        chk({tag, "_lb_wr_en_o"}, lb_wr_en_o, 0);
        chk({tag, "_lb_wr_row_o"}, lb_wr_row_o, 0);
        chk({tag, "_lb_wr_col_o"}, lb_wr_col_o, 0);
        chk({tag, "_win_valid_o"}, win_valid_o, 0);
        chk({tag, "_win_row_o"}, win_row_o, 0);
        chk({tag, "_win_col_o"}, win_col_o, 0);
        chk({tag, "_edge_valid_o"}, edge_valid_o, 0);
        chk({tag, "_edge_o"}, edge_o, 0);
        chk({tag, "_busy_o"}, busy_o, 0);
        chk({tag, "_done_o"}, done_o, 0);
    endtask

    task automatic stream_frame(input bit stalls, output int cyc);
        int beats;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("ready_after_start", pix_ready_o, 1);
        chk("busy_after_start", busy_o, 1);
        beats = 0;
        cyc   = 0;
        while (beats < 64 && cyc < 2000) begin
            pix_valid_i = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
            start_i     = stalls && (cyc == 15);
            #1;
            if (pix_valid_i && pix_ready_o) beats++;
            tick();
            cyc++;
        end
        pix_valid_i = 1'b0;
        start_i     = 1'b0;
        chk("beat_count_in_budget", beats, 64);
        chk("ready_low_after_last_beat", pix_ready_o, 0);
    endtask

    task automatic check_windows(input string tag);
        chk({tag, "_win_total"}, win_seen, 36);
        chk({tag, "_first_row"}, first_r, 1);
        chk({tag, "_first_col"}, first_c, 1);
        chk({tag, "_last_row"}, last_r, 6);
        chk({tag, "_last_col"}, last_c, 6);
    endtask

    task automatic run_results(input string tag);
        chk({tag, "_busy_wait_res"}, busy_o, 1);
        chk({tag, "_done_wait_res"}, done_o, 0);
        for (int i = 0; i < 36; i++) begin
            mag_valid_i = 1'b1;
            mag_i       = tbl[i % 6].mag;
            tick();
            chk({tag, "_edge_valid_o"}, edge_valid_o, 1);
            chk({tag, "_edge_o"}, edge_o, tbl[i % 6].exp_edge);
            chk({tag, "_done_o"}, done_o, (i == 35) ? 1 : 0);
        end
        chk({tag, "_busy_in_done"}, busy_o, 1);
        mag_i = 11'd2047;
        tick();
        mag_valid_i = 1'b0;
        chk({tag, "_extra_result_dropped"}, edge_valid_o, 0);
        chk({tag, "_done_single_pulse"}, done_o, 0);
        chk({tag, "_busy_falls"}, busy_o, 0);
    endtask

    initial begin
        int cyc;
        tbl[0] = '{mag: 11'd100,  exp_edge: 1'b0};
        tbl[1] = '{mag: 11'd101,  exp_edge: 1'b1};
        tbl[2] = '{mag: 11'd0,    exp_edge: 1'b0};
        tbl[3] = '{mag: 11'd2047, exp_edge: 1'b1};
        tbl[4] = '{mag: 11'd99,   exp_edge: 1'b0};
        tbl[5] = '{mag: 11'd255,  exp_edge: 1'b1};

        rst_n       = 1'b0;
        start_i     = 1'b0;
        pix_valid_i = 1'b0;
        mag_valid_i = 1'b0;
        mag_i       = '0;
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
        chk("idle_ready_low", pix_ready_o, 0);

        // Results offered while idle must be ignored.
        mag_valid_i = 1'b1;
        mag_i       = 11'd500;
        tick();
        mag_valid_i = 1'b0;
        chk("idle_result_ignored", edge_valid_o, 0);

        mon_en = 1'b1;
        stream_frame(1'b0, cyc);
        chk("back_to_back_cycles", cyc, 64);
        tick();
        check_windows("f1");
        run_results("f1");

        stream_frame(1'b1, cyc);
        tick();
        check_windows("f2");
        run_results("f2");
        mon_en = 1'b0;

        start_i = 1'b1;
        tick();
        start_i     = 1'b0;
        pix_valid_i = 1'b1;
        repeat (20) tick();
        chk("midframe_row", lb_wr_row_o, 2);
        chk("midframe_col", lb_wr_col_o, 4);
        pix_valid_i = 1'b0;
        rst_n       = 1'b0;
        tick();
        check_all_zero("midrst");
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle_busy", busy_o, 0);
        start_i = 1'b1;
        tick();
        start_i     = 1'b0;
        pix_valid_i = 1'b1;
        #1;
        chk("restart_lb_wr_en", lb_wr_en_o, 1);
        chk("restart_row", lb_wr_row_o, 0);
        chk("restart_col", lb_wr_col_o, 0);
        tick();
        chk("restart_next_col", lb_wr_col_o, 1);
        pix_valid_i = 1'b0;
        tick();
        chk("done_pulse_total", done_cnt, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sobel_frame_ctrl.md
SOBEL_FRAME_CTRL -- requirements
Module: sobel_frame_ctrl

Interface
REQ-001 SHALL have parameter IMAGE_ROW_SIZE, default 8: frame rows (legal >= 3).
REQ-002 SHALL have parameter IMAGE_COLUMN_SIZE, default 8: frame columns (legal >= 3).
REQ-003 SHALL have parameter THRESHOLD, default 100: edge decision level.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port start_i, input, 1: one-cycle frame start request.
REQ-007 SHALL have port pix_valid_i, input, 1: raster-order pixel offered.
REQ-008 SHALL have port pix_ready_o, output, 1: controller accepts pixel; beat = pix_valid_i & pix_ready_o.
REQ-009 SHALL have port lb_wr_en_o, output, 1: line-buffer write strobe to the Sobel datapath.
REQ-010 SHALL have port lb_wr_row_o, output, clog2(IMAGE_ROW_SIZE): row of the written pixel.
REQ-011 SHALL have port lb_wr_col_o, output, clog2(IMAGE_COLUMN_SIZE): column of the written pixel.
REQ-012 SHALL have port win_valid_o, output, 1: 3x3 window complete; datapath computes.
REQ-013 SHALL have port win_row_o, output, clog2(IMAGE_ROW_SIZE): window centre row.
REQ-014 SHALL have port win_col_o, output, clog2(IMAGE_COLUMN_SIZE): window centre column.
REQ-015 SHALL have port mag_valid_i, input, 1: datapath gradient result valid.
REQ-016 SHALL have port mag_i, input, 11: unsigned gradient magnitude |Gx|+|Gy|.
REQ-017 SHALL have port edge_valid_o, output, 1: edge_o valid.
REQ-018 SHALL have port edge_o, output, 1: edge decision.
REQ-019 SHALL have port busy_o, output, 1: frame in progress.
REQ-020 SHALL have port done_o, output, 1: one-cycle frame-complete pulse.

Function
REQ-021 FSM states SHALL be IDLE, STREAM, WAIT_RES, DONE.
REQ-022 IDLE -> STREAM on start_i; row/col counters, window count and result count cleared on that edge.
REQ-023 pix_ready_o SHALL be 1 only in STREAM; pixel and result inputs in IDLE/DONE are ignored.
REQ-024 Each beat: lb_wr_en_o=1 same cycle (combinational from beat), lb_wr_row_o/lb_wr_col_o = current counters.
REQ-025 After each beat col increments; col wraps to 0 after IMAGE_COLUMN_SIZE-1 and row increments.
REQ-026 Beat at (r,c) with r>=2 and c>=2 SHALL assert win_valid_o exactly one cycle later, win_row_o=r-1, win_col_o=c-1; no window on border pixels.
REQ-027 Window count total SHALL be (IMAGE_ROW_SIZE-2)*(IMAGE_COLUMN_SIZE-2) (36 at defaults).
REQ-028 Beat at (IMAGE_ROW_SIZE-1, IMAGE_COLUMN_SIZE-1) SHALL move STREAM -> WAIT_RES; pix_ready_o low from next cycle.
REQ-029 Each mag_valid_i in STREAM/WAIT_RES SHALL give edge_valid_o next cycle with edge_o = (mag_i > THRESHOLD), strict compare.
REQ-030 Results beyond the expected count SHALL be dropped (no edge_valid_o).
REQ-031 WAIT_RES -> DONE when result count reaches expected total, including a last result arriving in STREAM on the final-beat cycle.
REQ-032 DONE lasts one cycle with done_o=1, then -> IDLE.
REQ-033 busy_o=1 in STREAM, WAIT_RES, DONE.
REQ-034 start_i outside IDLE SHALL be ignored.
REQ-035 Stalls (pix_valid_i low) SHALL hold counters; no windows generated.

Reset
REQ-036 rst_n low at a clock edge SHALL force IDLE, clear all counters, and drive pix_ready_o, lb_wr_en_o, win_valid_o, edge_valid_o, edge_o, busy_o, done_o to 0, win/lb coordinates to 0.
REQ-037 Reset mid-frame SHALL abandon the frame; no done_o; next start_i begins a fresh frame at (0,0).

Verification
REQ-038 Defaults, start then 64 back-to-back beats -> 36 win_valid_o pulses, first at centre (1,1) one cycle after beat (2,2), last (6,6); pix_ready_o low after beat 64.
REQ-039 Feed mag_i = 100, 101, 0, 2047 -> edge_o = 0, 1, 0, 1, each one cycle after mag_valid_i.
REQ-040 Random pix_valid_i stalls -> identical window coordinate sequence, counters frozen during stalls.
REQ-041 36 results returned -> done_o single pulse, busy_o falls next cycle; extra 37th result -> no edge_valid_o.
REQ-042 rst_n low after beat 20 -> all outputs 0 next cycle; new start_i -> first lb write at (0,0).
REQ-043 start_i during STREAM -> ignored, counters unaffected.
